// File: rtl/mem_responder.sv
// Single-port word memory behind an IDLE/BUSY command handshake with fixed access latency.
// Define MEM_RESPONDER_ERR_EN to add MEM_Error reporting for misaligned/out-of-range accesses.
module mem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   output logic        MEM_Ready,
   input  logic        MEM_Cmd,
   input  logic        MEM_We,
   input  logic [1:0]  MEM_ByteEnable,
   input  logic [31:0] MEM_Addr,
   input  logic [31:0] MEM_DataIn,
   output logic [31:0] MEM_DataOut,
   output logic        MEM_DataReady
`ifdef MEM_RESPONDER_ERR_EN
   ,
   output logic        MEM_Error
`endif
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] capAddr;
   logic [31:0] capData;
   logic [1:0]  capBe;
   logic        capWe;

   logic [31:0] mem [0:DEPTH-1];

   logic [ADDR_WIDTH-1:0] wordIdx;
   logic [31:0] memWord;
   logic [31:0] rdData;
   logic [31:0] wrData;
   logic [3:0]  wrMask;
   logic        done;
   logic        accErr;

   assign wordIdx = capAddr[ADDR_WIDTH+1:2];
   assign memWord = mem[wordIdx];
   assign done    = (state == BUSY) && (cnt == 4'd1);

`ifdef MEM_RESPONDER_ERR_EN
   assign accErr = ((capBe == 2'b01) && capAddr[0])
                 || (capBe[1] && (capAddr[1:0] != 2'b00))
                 || ((capAddr >> (ADDR_WIDTH + 2)) != 32'd0);
`else
   // Upper address bits wrap; misaligned low bits are simply dropped by the lane decode.
   logic unusedAddrHi;
   assign unusedAddrHi = ^capAddr[31:ADDR_WIDTH+2];
   assign accErr = 1'b0;
`endif

   always_comb begin
      wrMask = 4'b1111;
      wrData = capData;
      rdData = memWord;
      if (capBe == 2'b00) begin
         wrMask = 4'b0001 << capAddr[1:0];
         wrData = {4{capData[7:0]}};
         rdData = {24'd0, memWord[{capAddr[1:0], 3'b000} +: 8]};
      end else if (capBe == 2'b01) begin
         wrMask = capAddr[1] ? 4'b1100 : 4'b0011;
         wrData = {2{capData[15:0]}};
         rdData = {16'd0, memWord[{capAddr[1], 4'b0000} +: 16]};
      end
   end

   // Memory has no reset; an async reset drops state to IDLE so no commit follows.
   always_ff @(posedge Clk) begin
      if (done && capWe && !accErr) begin
         for (int b = 0; b < 4; b++) begin
            if (wrMask[b]) mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state         <= IDLE;
         cnt           <= 4'd0;
         MEM_Ready     <= 1'b1;
         MEM_DataReady <= 1'b0;
         MEM_DataOut   <= 32'd0;
         capAddr       <= 32'd0;
         capData       <= 32'd0;
         capBe         <= 2'b00;
         capWe         <= 1'b0;
`ifdef MEM_RESPONDER_ERR_EN
         MEM_Error     <= 1'b0;
`endif
      end else begin
         MEM_DataReady <= 1'b0;
`ifdef MEM_RESPONDER_ERR_EN
         MEM_Error     <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (MEM_Cmd) begin
                  state     <= BUSY;
                  cnt       <= 4'(LATENCY);
                  MEM_Ready <= 1'b0;
                  capAddr   <= MEM_Addr;
                  capData   <= MEM_DataIn;
                  capBe     <= MEM_ByteEnable;
                  capWe     <= MEM_We;
               end
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (done) begin
                  state     <= IDLE;
                  MEM_Ready <= 1'b1;
                  if (!capWe) begin
                     MEM_DataReady <= 1'b1;
                     MEM_DataOut   <= accErr ? 32'd0 : rdData;
                  end
`ifdef MEM_RESPONDER_ERR_EN
                  MEM_Error <= accErr;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Table-driven bench for mem_responder with a read-data scoreboard and reset/busy corner sequences.
module tb_mem_responder;

   localparam int AW  = 10;
   localparam int LAT = 2;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        MEM_Ready;
   logic        MEM_Cmd;
   logic        MEM_We;
   logic [1:0]  MEM_ByteEnable;
   logic [31:0] MEM_Addr;
   logic [31:0] MEM_DataIn;
   logic [31:0] MEM_DataOut;
   logic        MEM_DataReady;
`ifdef MEM_RESPONDER_ERR_EN
   logic        MEM_Error;
   localparam logic ERR = 1'b1;
`else
   localparam logic ERR = 1'b0;
`endif

   mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
      .Clk(Clk), .Reset(Reset), .MEM_Ready(MEM_Ready), .MEM_Cmd(MEM_Cmd),
      .MEM_We(MEM_We), .MEM_ByteEnable(MEM_ByteEnable), .MEM_Addr(MEM_Addr),
      .MEM_DataIn(MEM_DataIn), .MEM_DataOut(MEM_DataOut), .MEM_DataReady(MEM_DataReady)
`ifdef MEM_RESPONDER_ERR_EN
      , .MEM_Error(MEM_Error)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        we;
      logic [1:0]  be;
      logic [31:0] addr;
      logic [31:0] din;
      logic [31:0] exp;
      logic        err;
      logic        poke;
   } vec_t;

   vec_t        tbl [15];
   logic [31:0] expQ [$];
   logic [31:0] lastRead;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Scoreboard: every DataReady pulse must match the oldest outstanding read.
   always @(negedge Clk) begin
      if (!Reset && MEM_DataReady) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_dataready actual=1 required=0 data=%h", MEM_DataOut);
         end else begin
            check("read_data", MEM_DataOut, expQ.pop_front());
         end
      end
   end

   task automatic waitReady();
      int n = 0;
      while (!MEM_Ready && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (!MEM_Ready) begin
         $display("FAIL ready_timeout actual=0 required=1");
         $fatal(1, "ready never returned");
      end
   endtask

   task automatic doAccess(input vec_t v);
      int lowCnt = 0;
      waitReady();
      MEM_Cmd = 1'b1; MEM_We = v.we; MEM_ByteEnable = v.be;
      MEM_Addr = v.addr; MEM_DataIn = v.din;
      if (!v.we) begin
         expQ.push_back(v.exp);
      end
      @(posedge Clk); #1;
      // Scramble inputs after acceptance; the captured command must not change.
      MEM_Cmd = v.poke; MEM_We = ~v.we; MEM_ByteEnable = ~v.be;
      MEM_Addr = $urandom; MEM_DataIn = $urandom;
      forever begin
         @(negedge Clk);
         MEM_Cmd = 1'b0;
         if (MEM_Ready || lowCnt > 40) break;
         lowCnt++;
      end
      check("ready_low_cycles", 32'(lowCnt), 32'(LAT));
      check("dataready_at_completion", {31'd0, MEM_DataReady}, {31'd0, ~v.we});
`ifdef MEM_RESPONDER_ERR_EN
      check("error_flag", {31'd0, MEM_Error}, {31'd0, v.err});
`endif
      if (v.we) check("dataout_held", MEM_DataOut, lastRead);
      else lastRead = v.exp;
      if (v.poke) begin
         for (int i = 0; i < LAT + 2; i++) begin
            @(negedge Clk);
            check("busy_cmd_ignored", {31'd0, MEM_Ready}, 32'd1);
         end
      end
   endtask

   initial begin
      //              we    be     addr          din           exp                               err   poke
      tbl[0]  = '{1'b1, 2'b10, 32'h10,   32'hDEADBEEF, 32'h0,                            1'b0, 1'b0};
      tbl[1]  = '{1'b0, 2'b10, 32'h10,   32'h0,        32'hDEADBEEF,                     1'b0, 1'b0};
      tbl[2]  = '{1'b1, 2'b11, 32'h10,   32'h11223344, 32'h0,                            1'b0, 1'b0};
      tbl[3]  = '{1'b1, 2'b00, 32'h13,   32'h555555AA, 32'h0,                            1'b0, 1'b0};
      tbl[4]  = '{1'b0, 2'b10, 32'h10,   32'h0,        32'hAA223344,                     1'b0, 1'b0};
      tbl[5]  = '{1'b0, 2'b00, 32'h13,   32'h0,        32'h000000AA,                     1'b0, 1'b0};
      tbl[6]  = '{1'b0, 2'b01, 32'h12,   32'h0,        32'h0000AA22,                     1'b0, 1'b1};
      tbl[7]  = '{1'b0, 2'b00, 32'h11,   32'h0,        32'h00000033,                     1'b0, 1'b0};
      tbl[8]  = '{1'b0, 2'b01, 32'h10,   32'h0,        32'h00003344,                     1'b0, 1'b0};
      tbl[9]  = '{1'b1, 2'b10, 32'h0,    32'h55667788, 32'h0,                            1'b0, 1'b0};
      tbl[10] = '{1'b1, 2'b10, 32'h1000, 32'hCAFEF00D, 32'h0,                            ERR,  1'b0};
      tbl[11] = '{1'b0, 2'b10, 32'h0,    32'h0,        ERR ? 32'h55667788 : 32'hCAFEF00D, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 2'b10, 32'h11,   32'h0,        ERR ? 32'h0 : 32'hAA223344,        ERR,  1'b0};
      tbl[13] = '{1'b1, 2'b01, 32'h2,    32'hFFFF9ABC, 32'h0,                            1'b0, 1'b0};
      tbl[14] = '{1'b0, 2'b10, 32'h0,    32'h0,        ERR ? 32'h9ABC7788 : 32'h9ABCF00D, 1'b0, 1'b0};

      Reset = 1'b1; MEM_Cmd = 1'b0; MEM_We = 1'b0; MEM_ByteEnable = 2'b00;
      MEM_Addr = 32'h0; MEM_DataIn = 32'h0; lastRead = 32'h0;
      #3;
      check("reset_ready", {31'd0, MEM_Ready}, 32'd1);
      check("reset_dataready", {31'd0, MEM_DataReady}, 32'd0);
      check("reset_dataout", MEM_DataOut, 32'h0);
      @(negedge Clk); @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);

      for (int i = 0; i < 15; i++) doAccess(tbl[i]);

      // Reset one cycle after a write is accepted: write is dropped, no completion.
      waitReady();
      MEM_Cmd = 1'b1; MEM_We = 1'b1; MEM_ByteEnable = 2'b10;
      MEM_Addr = 32'h10; MEM_DataIn = 32'h99999999;
      @(posedge Clk); #1;
      MEM_Cmd = 1'b0;
      @(negedge Clk);
      check("busy_before_reset", {31'd0, MEM_Ready}, 32'd0);
      Reset = 1'b1;
      #1;
      check("reset_mid_ready", {31'd0, MEM_Ready}, 32'd1);
      check("reset_mid_dataout", MEM_DataOut, 32'h0);
      lastRead = 32'h0;
      @(negedge Clk);
      Reset = 1'b0;
      for (int i = 0; i < LAT + 2; i++) begin
         @(negedge Clk);
         check("no_dataready_after_abort", {31'd0, MEM_DataReady}, 32'd0);
      end
      doAccess('{1'b0, 2'b10, 32'h10, 32'h0, 32'hAA223344, 1'b0, 1'b0});

      repeat (3) @(negedge Clk);
      check("scoreboard_drained", 32'(expQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, giving the word-address width (memory depth 2**ADDR_WIDTH 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, giving the cycles from command acceptance to completion; the legal range is 1..15.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port MEM_Ready, output, 1 bit: responder idle and able to accept a command.
REQ-006 SHALL have port MEM_Cmd, input, 1 bit: command request from the core.
REQ-007 SHALL have port MEM_We, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port MEM_ByteEnable, input, 2 bits: access size; 00 = byte, 01 = halfword, 1x = word.
REQ-009 SHALL have port MEM_Addr, input, 32 bits: byte address.
REQ-010 SHALL have port MEM_DataIn, input, 32 bits: write data, right-justified.
REQ-011 SHALL have port MEM_DataOut, output, 32 bits: read data, right-justified and zero-extended.
REQ-012 SHALL have port MEM_DataReady, output, 1 bit: one-cycle pulse marking read completion.

Function
REQ-013 SHALL implement states IDLE and BUSY; MEM_Ready SHALL be 1 exactly when the state is IDLE.
REQ-014 SHALL accept a command at edge T0 when MEM_Cmd=1 and MEM_Ready=1; at that edge it SHALL capture MEM_Addr, MEM_We, MEM_ByteEnable and MEM_DataIn, load the wait counter with LATENCY, and enter BUSY.
REQ-015 SHALL ignore MEM_Cmd while BUSY; captured values SHALL be unaffected by input changes after T0.
REQ-016 SHALL, at edge T0+LATENCY, complete the access and return to IDLE, so that MEM_Ready is 0 for exactly LATENCY cycles.
REQ-017 SHALL allow back-to-back commands: a command presented at edge T0+LATENCY+1 is accepted.
REQ-018 SHALL, on read completion, register MEM_DataOut and pulse MEM_DataReady for the one cycle following edge T0+LATENCY.
REQ-019 SHALL never assert MEM_DataReady for a write.
REQ-020 SHALL hold MEM_DataOut until the next read completes.
REQ-021 SHALL select read lanes as follows: a byte read selects the lane given by addr[1:0]; a halfword read selects the lane given by addr[1]; a word read returns the full word. Results are zero-extended; sign extension is the initiator's job.
REQ-022 SHALL commit writes at edge T0+LATENCY, writing only the addressed lanes: a byte write puts DataIn[7:0] at lane addr[1:0]; a halfword write puts DataIn[15:0] at lane addr[1]; a word write writes all four lanes.
REQ-023 SHALL take the word index from addr[ADDR_WIDTH+1:2].
REQ-024 SHALL let a read that follows a write to the same word return the newly written data.

Reset
REQ-025 SHALL, while Reset=1, force state=IDLE, MEM_Ready=1, MEM_DataReady=0, MEM_DataOut=0 and counter=0, independent of Clk.
REQ-026 SHALL abort any in-flight access on a Reset mid-operation; a pending write SHALL NOT be committed and no DataReady pulse SHALL occur.
REQ-027 SHALL NOT initialise or clear memory contents on reset.

Configuration
REQ-028 SHALL, when macro MEM_RESPONDER_ERR_EN is defined, add output MEM_Error (1 bit, reset 0). MEM_Error pulses coincident with completion when the access is misaligned (halfword with addr[0]=1, or word with addr[1:0]!=0) or out of range (addr[31:ADDR_WIDTH+2]!=0). A flagged write is suppressed; a flagged read returns 0 and MEM_DataReady still pulses.
REQ-029 SHALL, when MEM_RESPONDER_ERR_EN is undefined, have no MEM_Error port. Upper address bits are ignored (wrap-around) and misaligned halfword or word accesses are aligned down by ignoring the offending low bits.

Verification
REQ-030 Bench: word write 0xDEADBEEF at 0x10, then word read at 0x10 (LATENCY=2) -> MEM_Ready low for 2 cycles each; DataOut=0xDEADBEEF with a one-cycle DataReady 2 edges after accept.
REQ-031 Bench: byte write 0xAA at 0x13 over word 0x11223344 -> word read returns 0xAA223344; byte read at 0x13 returns 0x000000AA.
REQ-032 Bench: halfword read at 0x12 of 0xAA223344 -> 0x0000AA22; MEM_Cmd pulsed while BUSY -> ignored, no extra completion.
REQ-033 Bench: Reset asserted one cycle after write accept -> MEM_Ready=1 immediately; subsequent read shows the old data; no DataReady pulse.
REQ-034 Bench: with ERR_EN, word read at 0x11 -> MEM_Error=1, DataOut=0; with ERR_EN, write to 0x00001000 (ADDR_WIDTH=10) -> suppressed, MEM_Error=1. Without ERR_EN, the same write lands at word 0.
